// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the mixed-width dual-clock FIFO and its read-side
// drain engine.
//   - rd_state_t : drain FSM state encoding (IDLE, FETCH, LO, HI)
//   - RD_DEPTH   : FIFO depth in read-side (16-bit) words
//   - RD_WIDTH   : read-side word width
//   - WR_WIDTH   : write-side (byte) width, also the serialised output width
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int RD_DEPTH = 128;
  localparam int RD_WIDTH = 16;
  localparam int WR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LO    = 2'd2,
    HI    = 2'd3
  } rd_state_t;

endpackage

// File: rtl/fifo_rd_serializer.sv
// -----------------------------------------------------------------------------
// fifo_rd_serializer
// Read-side drain engine. Waits until a full burst of 16-bit words is buffered
// in the FIFO, then pops exactly BURST_LEN words and emits each one as two
// bytes (low byte first) on an 8-bit valid/ready stream, restoring the byte
// order in which the data was originally written.
//
// Parameters
//   BURST_LEN  : words popped per burst (1..128)
//   USEDW_W    : width of the FIFO read-side used-word count
// Ports
//   sys_clk    : FIFO read clock
//   sys_rst_n  : asynchronous active-low reset
//   en         : level enable, only looked at while idle
//   rd_empty   : FIFO empty flag
//   rd_usedw   : FIFO used-word count (may under-report)
//   rd_data    : FIFO read data, valid the cycle after rd_req, held until the
//                next rd_req
//   rd_req     : FIFO pop strobe
//   tx_data    : output byte
//   tx_valid   : output byte valid
//   tx_ready   : downstream accepts the byte
//   busy       : burst in progress
//   burst_done : one-cycle pulse after the last byte of a burst is accepted
// -----------------------------------------------------------------------------
module fifo_rd_serializer
  import fifo_pkg::*;
#(
  parameter int BURST_LEN = 64,
  parameter int USEDW_W   = 9
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                en,
  input  logic                rd_empty,
  input  logic [USEDW_W-1:0]  rd_usedw,
  input  logic [RD_WIDTH-1:0] rd_data,
  output logic                rd_req,
  output logic [WR_WIDTH-1:0] tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                burst_done
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  // Threshold compare is done one bit wider than either operand so that a
  // BURST_LEN that does not fit in USEDW_W bits still compares correctly.
  localparam int CMP_W = ((USEDW_W > CNT_W) ? USEDW_W : CNT_W) + 1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CMP_W-1:0] THRESH   = CMP_W'(BURST_LEN);

  rd_state_t        state;
  logic [CNT_W-1:0] word_cnt;   // words still to be popped in this burst
  logic             start;
  logic             last_word;

  assign start     = en && (CMP_W'(rd_usedw) >= THRESH);
  assign last_word = (word_cnt == '0);
  assign busy      = (state != IDLE);

  // Stream outputs are decoded from the state. rd_data is held by the FIFO
  // until the next pop, and a pop only happens once both bytes of the current
  // word have been accepted, so tx_data is stable under backpressure.
  always_comb begin
    rd_req   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    unique case (state)
      FETCH: begin
        rd_req = !rd_empty;
      end
      LO: begin
        tx_valid = 1'b1;
        tx_data  = rd_data[WR_WIDTH-1:0];
      end
      HI: begin
        tx_valid = 1'b1;
        tx_data  = rd_data[RD_WIDTH-1:WR_WIDTH];
        // Pop the next word in the same cycle the high byte is accepted so
        // the stream keeps one byte per cycle.
        rd_req   = tx_ready && !last_word && !rd_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      word_cnt   <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            word_cnt <= CNT_LOAD;
            state    <= FETCH;
          end
        end
        FETCH: begin
          // Stays here while the FIFO reports empty despite the count.
          if (rd_req) begin
            word_cnt <= word_cnt - CNT_ONE;
            state    <= LO;
          end
        end
        LO: begin
          if (tx_ready) begin
            state <= HI;
          end
        end
        HI: begin
          if (tx_ready) begin
            if (last_word) begin
              burst_done <= 1'b1;
              state      <= IDLE;
            end else if (rd_req) begin
              word_cnt <= word_cnt - CNT_ONE;
              state    <= LO;
            end else begin
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_serializer
// Drives fifo_rd_serializer from a behavioural FIFO (array + pointers) and
// checks the byte stream against the words written into that FIFO: byte k of
// the stream must be byte (k mod 2) of word k/2, every burst must carry
// 2*BURST_LEN bytes and BURST_LEN pops, and burst_done must follow the final
// byte of each burst. Directed sequences cover start latency, threshold
// gating, backpressure, underflow stall, reset mid-burst and enable drop;
// a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_fifo_rd_serializer;
  import fifo_pkg::*;

  localparam int BL    = 4;
  localparam int UW    = 9;
  localparam int MEM_N = 4096;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          en = 1'b0;
  logic          tx_ready = 1'b0;
  logic          force_empty = 1'b0;
  logic          flush = 1'b1;
  logic          rd_empty;
  logic [UW-1:0] rd_usedw;
  logic [15:0]   rd_data = '0;
  logic          rd_req;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          busy;
  logic          burst_done;

  logic [15:0] mem [0:MEM_N-1];
  int wr_ptr = 0;
  int rd_ptr = 0;

  int n_cmp = 0;
  int n_bad = 0;

  // scoreboard state, owned by the monitor process
  int         acc_cnt = 0;
  int         pop_cnt = 0;
  int         base = 0;
  int         burst_bytes = 0;
  int         burst_pops = 0;
  bit         done_exp = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  always #5 sys_clk = ~sys_clk;

  fifo_rd_serializer #(
    .BURST_LEN (BL),
    .USEDW_W   (UW)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .en         (en),
    .rd_empty   (rd_empty),
    .rd_usedw   (rd_usedw),
    .rd_data    (rd_data),
    .rd_req     (rd_req),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .burst_done (burst_done)
  );

  // Behavioural normal-mode FIFO read port.
  assign rd_empty = (wr_ptr == rd_ptr) || force_empty;
  assign rd_usedw = UW'(wr_ptr - rd_ptr);

  always @(posedge sys_clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (rd_req) begin
      rd_data <= mem[rd_ptr % MEM_N];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    mem[wr_ptr % MEM_N] = w;
    wr_ptr++;
  endtask

  task automatic push4(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    @(posedge sys_clk); #1;
    push_word(a); push_word(b); push_word(c); push_word(d);
  endtask

  task automatic wait_byte(input string tag, input logic [7:0] val, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge sys_clk);
      if (tx_valid && tx_data == val) found = 1'b1;
    end
    check(tag, found, 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge sys_clk);
      if (burst_done) found = 1'b1;
    end
    check(tag, found, 1);
    $display("burst %s: done=%0d words_written=%0d words_read=%0d", tag, found, wr_ptr, rd_ptr);
  endtask

  // Stream monitor / scoreboard, sampled on the falling edge.
  task automatic monitor();
    logic [15:0] w;
    logic [7:0]  eb;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n || flush) begin
        acc_cnt = 0; pop_cnt = 0; base = wr_ptr;
        burst_bytes = 0; burst_pops = 0;
        done_exp = 1'b0; prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", tx_valid, 1);
          check("hold_data", tx_data, prev_data);
        end
        check("burst_done", burst_done, done_exp);
        if (burst_done) begin
          check("burst_bytes", burst_bytes, 2 * BL);
          check("burst_pops", burst_pops, BL);
          check("done_idle", busy, 0);
          burst_bytes = 0;
          burst_pops  = 0;
        end
        done_exp = 1'b0;
        if (tx_valid && tx_ready) begin
          w  = mem[(base + acc_cnt / 2) % MEM_N];
          eb = (acc_cnt % 2 == 1) ? w[15:8] : w[7:0];
          check("byte", tx_data, eb);
          acc_cnt++;
          burst_bytes++;
          done_exp = (burst_bytes == 2 * BL);
        end
        if (rd_req) begin
          check("pop_empty", rd_empty, 0);
          check("pop_unsent", 2 * pop_cnt, acc_cnt);
          check("pop_count", burst_pops < BL, 1);
          pop_cnt++;
          burst_pops++;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none

    // ---- reset state ----
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_rd_req", rd_req, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", burst_done, 0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    flush     = 1'b0;

    // ---- single burst, continuous drain ----
    en = 1'b1;
    tx_ready = 1'b1;
    push4(16'h2211, 16'h4433, 16'h6655, 16'h8877);
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("start_rd_req", rd_req, 1);
    check("start_busy", busy, 1);
    check("start_no_valid", tx_valid, 0);
    for (int k = 0; k < 2 * BL; k++) begin
      @(negedge sys_clk);
      check("stream_valid", tx_valid, 1);
    end
    @(negedge sys_clk);
    check("single_done", burst_done, 1);
    $display("burst single: bytes checked through scoreboard");

    // ---- threshold gating ----
    @(posedge sys_clk); #1;
    push_word(16'h0a0b); push_word(16'h0c0d); push_word(16'h0e0f);
    repeat (5) begin
      @(negedge sys_clk);
      check("thr_no_req", rd_req, 0);
      check("thr_not_busy", busy, 0);
    end
    @(posedge sys_clk); #1;
    push_word(16'h1020);
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("thr_start", rd_req, 1);
    wait_done("threshold", 40);

    // ---- backpressure on the high byte ----
    push4(16'h0102, 16'hA1B2, 16'h0304, 16'h0506);
    wait_byte("bp_lo_seen", 8'hB2, 40);
    @(posedge sys_clk); #1;
    tx_ready = 1'b0;
    repeat (2) begin
      @(negedge sys_clk);
      check("bp_hold_data", tx_data, 8'hA1);
      check("bp_hold_valid", tx_valid, 1);
      check("bp_no_req", rd_req, 0);
      @(posedge sys_clk); #1;
    end
    tx_ready = 1'b1;
    wait_done("backpressure", 40);

    // ---- underflow stall ----
    push4(16'h1A2B, 16'h3C4D, 16'h5E6F, 16'h7081);
    wait_byte("uf_word2", 8'h4D, 40);
    @(posedge sys_clk); #1;
    force_empty = 1'b1;
    @(negedge sys_clk);
    check("uf_hi_byte", tx_data, 8'h3C);
    repeat (4) begin
      @(negedge sys_clk);
      check("uf_no_req", rd_req, 0);
      check("uf_busy", busy, 1);
      check("uf_no_valid", tx_valid, 0);
    end
    @(posedge sys_clk); #1;
    force_empty = 1'b0;
    wait_done("underflow", 40);

    // ---- reset mid-burst ----
    push4(16'h1122, 16'h3344, 16'h5566, 16'h7788);
    wait_byte("rst_word2_lo", 8'h44, 40);
    #1;
    sys_rst_n = 1'b0;
    flush     = 1'b1;
    #1;
    check("arst_rd_req", rd_req, 0);
    check("arst_tx_valid", tx_valid, 0);
    check("arst_tx_data", tx_data, 0);
    check("arst_busy", busy, 0);
    check("arst_done", burst_done, 0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    flush     = 1'b0;
    @(posedge sys_clk); #1;
    push_word(16'h9a9b); push_word(16'h9c9d); push_word(16'h9e9f);
    repeat (4) begin
      @(negedge sys_clk);
      check("post_rst_no_req", rd_req, 0);
      check("post_rst_idle", busy, 0);
    end
    @(posedge sys_clk); #1;
    push_word(16'hA0A1);
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("post_rst_start", rd_req, 1);
    wait_done("post_reset", 40);

    // ---- enable drop mid-burst ----
    push4(16'hC1C2, 16'hC3C4, 16'hC5C6, 16'hC7C8);
    wait_byte("en_first_byte", 8'hC2, 40);
    @(posedge sys_clk); #1;
    en = 1'b0;
    wait_done("en_drop", 40);
    push4(16'hD1D2, 16'hD3D4, 16'hD5D6, 16'hD7D8);
    repeat (8) begin
      @(negedge sys_clk);
      check("en_off_no_req", rd_req, 0);
      check("en_off_idle", busy, 0);
    end
    @(posedge sys_clk); #1;
    en = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("en_on_start", rd_req, 1);
    wait_done("en_restart", 40);

    // ---- randomized traffic ----
    for (int c = 0; c < 800; c++) begin
      @(posedge sys_clk); #1;
      tx_ready    = ($urandom_range(3) != 0);
      force_empty = ($urandom_range(7) == 0);
      en          = ($urandom_range(9) != 0);
      if ((wr_ptr - rd_ptr) < 100 && $urandom_range(1) == 1)
        push_word(16'($urandom));
    end
    tx_ready    = 1'b1;
    force_empty = 1'b0;
    en          = 1'b1;
    begin
      bit drained = 1'b0;
      for (int c = 0; c < 3000 && !drained; c++) begin
        @(negedge sys_clk);
        if (!busy && (wr_ptr - rd_ptr) < BL) drained = 1'b1;
      end
      check("rand_drained", drained, 1);
    end
    repeat (3) @(negedge sys_clk);
    check("rand_idle", busy, 0);
    check("rand_leftover", (wr_ptr - rd_ptr) < BL, 1);
    $display("random phase: words_written=%0d words_read=%0d bytes_checked=%0d", wr_ptr, rd_ptr, acc_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
